// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared definitions for the ALU built-in self-test engine.
//   - ALU control-code constants
//   - test-vector width and field bit offsets
//   - FSM state encoding
//   - mk_vec(): packs one vector, used by the ROM case table
package alu_bist_pkg;

  localparam logic [5:0] CTL_ADD  = 6'b000000;
  localparam logic [5:0] CTL_SLL  = 6'b000001;
  localparam logic [5:0] CTL_SLT  = 6'b000010;
  localparam logic [5:0] CTL_XOR  = 6'b000100;
  localparam logic [5:0] CTL_SRL  = 6'b000101;
  localparam logic [5:0] CTL_OR   = 6'b000110;
  localparam logic [5:0] CTL_AND  = 6'b000111;
  localparam logic [5:0] CTL_SUB  = 6'b001000;
  localparam logic [5:0] CTL_SRA  = 6'b001101;
  localparam logic [5:0] CTL_BEQ  = 6'b010000;
  localparam logic [5:0] CTL_BNE  = 6'b010001;
  localparam logic [5:0] CTL_BGE  = 6'b010101;
  localparam logic [5:0] CTL_BLTU = 6'b010110;
  localparam logic [5:0] CTL_BGEU = 6'b010111;
  localparam logic [5:0] CTL_PASS = 6'b111111;

  // Vector layout, MSB first: control | branch_op | operand_a | operand_b | exp_result | exp_branch
  localparam int VEC_W   = 104;
  localparam int CTL_LSB = 98;
  localparam int BOP_BIT = 97;
  localparam int OPA_LSB = 65;
  localparam int OPB_LSB = 33;
  localparam int EXR_LSB = 1;
  localparam int EXB_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRIVE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [VEC_W-1:0] mk_vec(
    input logic [5:0]  ctl,
    input logic        bop,
    input logic [31:0] opa,
    input logic [31:0] opb,
    input logic [31:0] exr,
    input logic        exb
  );
    return {ctl, bop, opa, opb, exr, exb};
  endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// alu_bist_rom: test-vector ROM, one-cycle registered read.
//   clock_i  rising-edge clock
//   idx_i    vector index to read
//   data_o   registered vector (layout in alu_bist_pkg)
// Indices past the explicit table return ADD idx+idx, so any NUM_VECTORS
// up to 256 still yields self-consistent vectors.
module alu_bist_rom
  import alu_bist_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clock_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [VEC_W-1:0] data_o
);

  logic [VEC_W-1:0] vec_d;
  logic [VEC_W-1:0] data_q;
  logic [31:0]      idx32;

  assign idx32 = 32'(idx_i);

  always_comb begin
    vec_d = mk_vec(CTL_ADD, 1'b0, idx32, idx32, idx32 + idx32, 1'b0);
    case (idx32)
      32'd0:  vec_d = mk_vec(CTL_ADD,  1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0);
      32'd1:  vec_d = mk_vec(CTL_ADD,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
      32'd2:  vec_d = mk_vec(CTL_SLL,  1'b0, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0);
      32'd3:  vec_d = mk_vec(CTL_SLT,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
      32'd4:  vec_d = mk_vec(CTL_XOR,  1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
      32'd5:  vec_d = mk_vec(CTL_SUB,  1'b0, 32'h0000_0020, 32'h0000_000F, 32'h0000_0011, 1'b0);
      32'd6:  vec_d = mk_vec(CTL_SRL,  1'b0, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0);
      32'd7:  vec_d = mk_vec(CTL_OR,   1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0);
      32'd8:  vec_d = mk_vec(CTL_AND,  1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0);
      32'd9:  vec_d = mk_vec(CTL_SRA,  1'b0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0);
      32'd10: vec_d = mk_vec(CTL_BEQ,  1'b1, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b1);
      32'd11: vec_d = mk_vec(CTL_BNE,  1'b1, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1);
      32'd12: vec_d = mk_vec(CTL_BGE,  1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
      32'd13: vec_d = mk_vec(CTL_BLTU, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      32'd14: vec_d = mk_vec(CTL_BGEU, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
      32'd15: vec_d = mk_vec(CTL_PASS, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b0);
      32'd16: vec_d = mk_vec(CTL_SUB,  1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) data_q <= vec_d;

  assign data_o = data_q;

endmodule

// File: rtl/alu_bist.sv
// alu_bist: ALU built-in self-test engine.
// Walks the vector ROM: FETCH (ROM read) -> DRIVE (SETTLE_CYCLES) -> CHECK,
// counting vectors whose result or branch flag disagree with the ROM.
//   clock_i/reset_i      clock, synchronous active-high reset
//   start_i              begin a run (honoured only in IDLE or DONE)
//   busy_o/done_o/pass_o run status; pass valid with done
//   fail_count_o         mismatching vectors, saturating at 255
//   vec_index_o          vector currently driven
//   alu_*_o              ALU stimulus, zero outside DRIVE/CHECK
//   alu_result_i/alu_branch_i  ALU response
//   first_fail_*_o       first mismatch capture; built only with
//                        ALU_BIST_CAPTURE_EN defined, otherwise tied to 0
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int NUM_VECTORS   = 32,
  parameter int IDX_W         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [7:0]       fail_count_o,
  output logic [IDX_W-1:0] vec_index_o,
  output logic [5:0]       alu_control_o,
  output logic             alu_branch_op_o,
  output logic [31:0]      alu_operand_a_o,
  output logic [31:0]      alu_operand_b_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_branch_i,
  output logic [IDX_W-1:0] first_fail_index_o,
  output logic [31:0]      first_fail_result_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       fail_q, fail_d;
  logic [VEC_W-1:0] rom_data;
  logic             active, launch, mismatch;

  // ROM address is the live index: it is stable through FETCH, so the
  // registered word is valid from the first DRIVE cycle onward.
  alu_bist_rom #(.IDX_W(IDX_W)) u_rom (
    .clock_i (clock_i),
    .idx_i   (idx_q),
    .data_o  (rom_data)
  );

  // The ROM output register doubles as the stimulus register; gating by
  // state keeps the ALU inputs at zero outside DRIVE/CHECK.
  assign active   = (state_q == S_DRIVE) || (state_q == S_CHECK);
  assign launch   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
  assign mismatch = (alu_result_i != rom_data[EXR_LSB +: 32]) ||
                    (alu_branch_i != rom_data[EXB_BIT]);

  assign alu_control_o   = active ? rom_data[CTL_LSB +: 6]  : '0;
  assign alu_branch_op_o = active ? rom_data[BOP_BIT]       : 1'b0;
  assign alu_operand_a_o = active ? rom_data[OPA_LSB +: 32] : '0;
  assign alu_operand_b_o = active ? rom_data[OPB_LSB +: 32] : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_FETCH;
          idx_d   = '0;
          fail_d  = '0;
        end
      end
      S_FETCH: begin
        state_d = S_DRIVE;
        cnt_d   = '0;
      end
      S_DRIVE: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = S_CHECK;
        else                                cnt_d   = cnt_q + 4'd1;
      end
      S_CHECK: begin
        if (mismatch && (fail_q != 8'hFF)) fail_d = fail_q + 8'd1;
        if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  assign busy_o       = (state_q == S_FETCH) || active;
  assign done_o       = (state_q == S_DONE);
  assign pass_o       = done_o && (fail_q == 8'd0);
  assign fail_count_o = fail_q;
  assign vec_index_o  = idx_q;

`ifdef ALU_BIST_CAPTURE_EN
  logic             seen_q, seen_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;
  logic [31:0]      ffr_q, ffr_d;

  always_comb begin
    seen_d = seen_q;
    ffi_d  = ffi_q;
    ffr_d  = ffr_q;
    if (launch) begin
      seen_d = 1'b0;
      ffi_d  = '0;
      ffr_d  = '0;
    end else if ((state_q == S_CHECK) && mismatch && !seen_q) begin
      seen_d = 1'b1;
      ffi_d  = idx_q;
      ffr_d  = alu_result_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      seen_q <= 1'b0;
      ffi_q  <= '0;
      ffr_q  <= '0;
    end else begin
      seen_q <= seen_d;
      ffi_q  <= ffi_d;
      ffr_q  <= ffr_d;
    end
  end

  assign first_fail_index_o  = ffi_q;
  assign first_fail_result_o = ffr_q;
`else
  logic unused_launch;
  assign unused_launch       = launch;
  assign first_fail_index_o  = '0;
  assign first_fail_result_o = '0;
`endif

endmodule
